// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg : shared state codes and timer width for the sync sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sync_pkg;

  localparam int TO_W_DEF = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEARCH  = 3'd1;
  localparam logic [2:0] ST_FO_EST  = 3'd2;
  localparam logic [2:0] ST_FINE    = 3'd3;
  localparam logic [2:0] ST_DEMOD   = 3'd4;
  localparam logic [2:0] ST_HOLDOFF = 3'd5;

  // Coarse sync block is held out of clear for the whole acquisition chain.
  function automatic logic in_chain(input logic [2:0] st);
    return (st == ST_SEARCH) || (st == ST_FO_EST) ||
           (st == ST_FINE) || (st == ST_DEMOD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_phase_timer.sv
// ---------------------------------------------------------------------------
// sync_phase_timer : saturating per-phase cycle counter with limit compare.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_phase_timer
  import sync_pkg::*;
#(
  parameter int TO_W = TO_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [TO_W-1:0] limit,
  output logic [TO_W-1:0] count,
  output logic            at_limit
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != {TO_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count == limit);

endmodule

`default_nettype wire

// File: rtl/sync_sequencer.sv
// ---------------------------------------------------------------------------
// sync_sequencer : receiver acquisition FSM (search/FO/fine/demod/holdoff).
// rst is asynchronous active-low. Optional SYNC_STATS_EN adds frame/timeout
// statistics counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_sequencer
  import sync_pkg::*;
#(
  parameter int              TO_W      = TO_W_DEF,
  parameter logic [TO_W-1:0] SEARCH_TO = 16'd40000,
  parameter logic [TO_W-1:0] FO_TO     = 16'd256,
  parameter logic [TO_W-1:0] FINE_TO   = 16'd512,
  parameter logic [TO_W-1:0] HOLDOFF   = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_on,
  input  logic        coarse_det,
  input  logic        fo_done,
  input  logic        fine_done,
  input  logic        frame_end,
  output logic        cts_ena,
  output logic        cts_cyc,
  output logic        fo_ena,
  output logic        fine_ena,
  output logic        dem_ena,
  output logic [2:0]  sync_state,
  output logic        timeout
`ifdef SYNC_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] timeouts
`endif
);

  localparam logic [TO_W-1:0] HOLD_LAST = HOLDOFF - 1'b1;

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic            timeout_nx;
  logic [TO_W-1:0] limit;
  logic [TO_W-1:0] count;
  logic            at_limit;
  logic            clear;

  always_comb begin
    limit = {TO_W{1'b1}};
    case (state)
      ST_SEARCH:  limit = SEARCH_TO;
      ST_FO_EST:  limit = FO_TO;
      ST_FINE:    limit = FINE_TO;
      ST_HOLDOFF: limit = HOLD_LAST;
      default:    limit = {TO_W{1'b1}};
    endcase
  end

  // Priority: rx_on drop, then completion, then timeout.
  always_comb begin
    state_nx   = state;
    timeout_nx = 1'b0;
    if (state == ST_IDLE) begin
      if (rx_on) state_nx = ST_SEARCH;
    end else if (!rx_on && state != ST_HOLDOFF) begin
      state_nx = ST_HOLDOFF;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (coarse_det)    state_nx = ST_FO_EST;
          else if (at_limit) begin state_nx = ST_HOLDOFF; timeout_nx = 1'b1; end
        end
        ST_FO_EST: begin
          if (fo_done)       state_nx = ST_FINE;
          else if (at_limit) begin state_nx = ST_HOLDOFF; timeout_nx = 1'b1; end
        end
        ST_FINE: begin
          if (fine_done)     state_nx = ST_DEMOD;
          else if (at_limit) begin state_nx = ST_HOLDOFF; timeout_nx = 1'b1; end
        end
        ST_DEMOD: begin
          if (frame_end)     state_nx = ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (at_limit)      state_nx = rx_on ? ST_SEARCH : ST_IDLE;
        end
        default:             state_nx = ST_HOLDOFF;
      endcase
    end
  end

  assign clear = (state_nx != state);

  sync_phase_timer #(.TO_W(TO_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .limit    (limit),
    .count    (count),
    .at_limit (at_limit)
  );

  // timeout is registered, so its pulse lines up with the first HOLDOFF cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      timeout <= timeout_nx;
    end
  end

  assign sync_state = state;
  assign cts_ena    = (state == ST_SEARCH);
  assign cts_cyc    = in_chain(state);
  assign fo_ena     = (state == ST_FO_EST);
  assign fine_ena   = (state == ST_FINE);
  assign dem_ena    = (state == ST_DEMOD);

`ifdef SYNC_STATS_EN
  logic frame_good;
  assign frame_good = (state == ST_DEMOD) && (state_nx == ST_HOLDOFF) && rx_on && frame_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_ok <= '0;
      timeouts  <= '0;
    end else begin
      if (frame_good && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
      if (timeout_nx && timeouts != 16'hFFFF)  timeouts  <= timeouts + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/sync_sequencer.md
SYNC_SEQUENCER -- requirements
Module: sync_sequencer

Interface
REQ-001 SHALL have parameter TO_W, default 16: width of the phase timeout counter.
REQ-002 SHALL have parameter SEARCH_TO, default 16'd40000: max SEARCH cycles before timeout.
REQ-003 SHALL have parameter FO_TO, default 16'd256: max FO_EST cycles.
REQ-004 SHALL have parameter FINE_TO, default 16'd512: max FINE cycles.
REQ-005 SHALL have parameter HOLDOFF, default 16'd8: cycles in HOLDOFF with the coarse block cleared.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port rx_on, input, 1: receiver enabled by the host.
REQ-009 SHALL have port coarse_det, input, 1: plateau/coarse-timing detect from the coarse sync block, level.
REQ-010 SHALL have port fo_done, input, 1: frequency-offset estimate valid, pulse.
REQ-011 SHALL have port fine_done, input, 1: fine timing locked, pulse.
REQ-012 SHALL have port frame_end, input, 1: demodulator finished the frame, pulse.
REQ-013 SHALL have port cts_ena, output, 1: drives coarse sync ena.
REQ-014 SHALL have port cts_cyc, output, 1: drives coarse sync cyc_i; low clears it.
REQ-015 SHALL have outputs fo_ena, fine_ena, dem_ena, output, 1 each: stage enables.
REQ-016 SHALL have port sync_state, output, 3: current state code.
REQ-017 SHALL have port timeout, output, 1: one-cycle pulse when any phase times out.

Function
REQ-018 SHALL implement the FSM IDLE=0, SEARCH=1, FO_EST=2, FINE=3, DEMOD=4, HOLDOFF=5; codes 6-7 SHALL go to HOLDOFF.
REQ-019 SHALL move IDLE->SEARCH when rx_on=1.
REQ-020 SHALL move SEARCH->FO_EST on coarse_det=1, FO_EST->FINE on fo_done, FINE->DEMOD on fine_done, DEMOD->HOLDOFF on frame_end.
REQ-021 SHALL move SEARCH/FO_EST/FINE->HOLDOFF when the phase counter equals that phase's limit, pulsing timeout that cycle.
REQ-022 SHALL move HOLDOFF->SEARCH after exactly HOLDOFF cycles if rx_on=1, else to IDLE.
REQ-023 SHALL move any non-IDLE state to HOLDOFF when rx_on=0, with no timeout pulse.
REQ-024 SHALL reset the phase counter to 0 on every state change and increment it by 1 otherwise, saturating at all-ones.
REQ-025 SHALL give a completion event priority over a timeout in the same cycle; rx_on=0 SHALL have priority over both.
REQ-026 SHALL ignore completion pulses that arrive outside their own state.
REQ-027 SHALL decode outputs as Moore outputs of the state register (0 cycles after entry):
- cts_ena=1 in SEARCH.
- cts_cyc=1 in SEARCH..DEMOD, 0 in IDLE/HOLDOFF.
- fo_ena=1 in FO_EST; fine_ena=1 in FINE; dem_ena=1 in DEMOD.

Reset
REQ-028 SHALL, while rst=0, asynchronously force state=IDLE, counter=0, timeout=0, and all enables and cts_cyc=0.
REQ-029 SHALL, on reset mid-frame, take effect immediately, dropping every enable without passing through HOLDOFF.

Configuration
REQ-030 SHALL, with SYNC_STATS_EN defined, add outputs frames_ok[15:0] (increments on DEMOD->HOLDOFF via frame_end) and timeouts[15:0] (increments per timeout pulse), both saturating and cleared by reset.
REQ-031 SHALL, without SYNC_STATS_EN, omit both ports and counters entirely.

Structure
REQ-032 SHALL take the state codes and the TO_W default from shared package sync_pkg.
REQ-033 SHALL put the saturating phase counter with limit compare in sub-module sync_phase_timer, instantiated once.

Verification
REQ-034 Bench SHALL check the nominal frame: rx_on=1, coarse_det at cycle 100, fo_done +20, fine_done +30, frame_end +500 -> states 1,2,3,4,5 then 1 after 8 HOLDOFF cycles, timeout never pulses.
REQ-035 Bench SHALL check search timeout: no coarse_det -> timeout pulse at SEARCH cycle 40000, HOLDOFF with cts_cyc=0 for 8 cycles, back to SEARCH.
REQ-036 Bench SHALL check collision: fo_done in the same cycle FO_EST hits 256 -> FINE, no timeout.
REQ-037 Bench SHALL check abort: rx_on=0 in DEMOD -> HOLDOFF next cycle, then IDLE after 8 cycles, dem_ena=0.
REQ-038 Bench SHALL check async reset: rst=0 mid-FINE -> all outputs 0 before the next clk edge, state=0.
REQ-039 Bench SHALL check stats with SYNC_STATS_EN: 3 good frames plus 2 timeouts -> frames_ok=3, timeouts=2.
